// File: rtl/hazard_pkg.sv
// Shared types and helpers for the operand-fetch data-hazard controller.
package hazard_pkg;

  // Scoreboard fields are sized for the widest supported configuration;
  // narrower register addresses are zero-extended on entry and on compare.
  localparam int unsigned MaxRegW = 16;
  localparam int unsigned MaxLatW = 4;

  localparam int unsigned FWD_RF = 0;

  typedef struct packed {
    logic               valid;
    logic [MaxRegW-1:0] dst;
    logic [MaxLatW-1:0] lat;
  } sb_entry_t;

  function automatic int unsigned sel_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Single-operand scoreboard comparator with youngest-match priority.
module hazard_cmp
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W    = 6,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned SW       = sel_width(DEPTH),
  parameter bit          FWD_EN   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  sb_entry_t [DEPTH-1:0] sb,
  input  logic [REG_W-1:0]      src,
  input  logic                  src_en,
  output logic                  hold_req,
  output logic [SW-1:0]         sel
);

  logic               found;
  logic               hit_ready;
  logic               active;
  logic [SW-1:0]      hit_sel;
  logic [MaxRegW-1:0] src_ext;

  assign src_ext = MaxRegW'(src);

  always_comb begin
    found     = 1'b0;
    hit_ready = 1'b0;
    hit_sel   = '0;
    // Walk oldest to youngest so the lowest-index match is the one that sticks.
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (sb[k].valid && (sb[k].dst == src_ext)) begin
        found     = 1'b1;
        hit_ready = (sb[k].lat == '0);
        hit_sel   = SW'(k + 1);
      end
    end
  end

  always_comb begin
    active   = src_en && !(ZERO_REG && (src == '0)) && found;
    hold_req = active && (!FWD_EN || !hit_ready);
    sel      = (active && !hold_req) ? hit_sel : SW'(FWD_RF);
  end

endmodule

// File: rtl/hazard_unit.sv
// Data-hazard controller: in-flight write scoreboard, forwarding select,
// front-end hold and saturating stall counter.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W    = 6,
  parameter int unsigned N_SRC    = 2,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 2,
  parameter bit          FWD_EN   = 1'b1,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned SW      = sel_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   issue_valid,
  input  logic [N_SRC*REG_W-1:0] issue_src,
  input  logic [N_SRC-1:0]       issue_src_rd,
  input  logic                   issue_wr,
  input  logic [REG_W-1:0]       issue_dst,
  input  logic                   issue_is_load,
  input  logic                   flush,
  output logic                   hold_registers,
  output logic [N_SRC*SW-1:0]    fwd_sel,
  output logic [15:0]            stall_cycles
);

  sb_entry_t [DEPTH-1:0]      sb_q, sb_d;
  logic [N_SRC-1:0]           hold_req;
  logic [N_SRC-1:0][SW-1:0]   sel_vec;
  logic [15:0]                stall_q, stall_d;

  for (genvar i = 0; i < N_SRC; i++) begin : g_cmp
    hazard_cmp #(
      .REG_W    (REG_W),
      .DEPTH    (DEPTH),
      .SW       (SW),
      .FWD_EN   (FWD_EN),
      .ZERO_REG (ZERO_REG)
    ) u_cmp (
      .sb       (sb_q),
      .src      (issue_src[i*REG_W +: REG_W]),
      .src_en   (issue_valid & issue_src_rd[i]),
      .hold_req (hold_req[i]),
      .sel      (sel_vec[i])
    );
  end

  always_comb begin
    hold_registers = (|hold_req) & ~flush;
    fwd_sel        = hold_registers ? '0 : sel_vec;
  end

  always_comb begin
    sb_d = '0;
    if (!flush) begin
      // A held instruction enters as a bubble so it cannot match itself later.
      sb_d[0].valid = issue_valid & issue_wr & ~hold_registers;
      sb_d[0].dst   = MaxRegW'(issue_dst);
      sb_d[0].lat   = issue_is_load ? MaxLatW'(LOAD_LAT - 1) : '0;
      for (int k = 1; k < int'(DEPTH); k++) begin
        sb_d[k]     = sb_q[k-1];
        sb_d[k].lat = (sb_q[k-1].lat != '0) ? sb_q[k-1].lat - 1'b1 : '0;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (hold_registers && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_q    <= '0;
      stall_q <= '0;
    end else begin
      sb_q    <= sb_d;
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (forwarding, no-forwarding
// and deep saturation configurations driven side by side).
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        issue_valid;
  logic [11:0] issue_src;
  logic [1:0]  issue_src_rd;
  logic        issue_wr;
  logic [5:0]  issue_dst;
  logic        issue_is_load;
  logic        flush;
  logic        sat_run;

  logic        hold_a, hold_n, hold_s;
  logic [3:0]  fwd_a, fwd_n, fwd_s;
  logic [15:0] stall_a, stall_n, stall_s;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  hazard_unit u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .issue_valid    (issue_valid),
    .issue_src      (issue_src),
    .issue_src_rd   (issue_src_rd),
    .issue_wr       (issue_wr),
    .issue_dst      (issue_dst),
    .issue_is_load  (issue_is_load),
    .flush          (flush),
    .hold_registers (hold_a),
    .fwd_sel        (fwd_a),
    .stall_cycles   (stall_a)
  );

  hazard_unit #(.FWD_EN(1'b0)) u_dut_nf (
    .clk            (clk),
    .reset_n        (reset_n),
    .issue_valid    (issue_valid),
    .issue_src      (issue_src),
    .issue_src_rd   (issue_src_rd),
    .issue_wr       (issue_wr),
    .issue_dst      (issue_dst),
    .issue_is_load  (issue_is_load),
    .flush          (flush),
    .hold_registers (hold_n),
    .fwd_sel        (fwd_n),
    .stall_cycles   (stall_n)
  );

  // Self-dependent write stream: with no forwarding and 15 stages it holds
  // 15 of every 16 cycles, enough to saturate the counter quickly.
  hazard_unit #(.N_SRC(1), .DEPTH(15), .LOAD_LAT(1), .FWD_EN(1'b0)) u_dut_sat (
    .clk            (clk),
    .reset_n        (reset_n),
    .issue_valid    (sat_run),
    .issue_src      (6'd1),
    .issue_src_rd   (1'b1),
    .issue_wr       (sat_run),
    .issue_dst      (6'd1),
    .issue_is_load  (1'b0),
    .flush          (1'b0),
    .hold_registers (hold_s),
    .fwd_sel        (fwd_s),
    .stall_cycles   (stall_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] s0, input logic [5:0] s1,
                       input logic [1:0] rd, input logic wr, input logic [5:0] dst,
                       input logic ld, input logic fl);
    issue_valid   = v;
    issue_src     = {s1, s0};
    issue_src_rd  = rd;
    issue_wr      = wr;
    issue_dst     = dst;
    issue_is_load = ld;
    flush         = fl;
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 6'd0, 2'b00, 1'b0, 6'd0, 1'b0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (4) next_cycle();
  endtask

  initial begin
    bit seen;
    reset_n = 1'b0;
    sat_run = 1'b0;
    idle();
    #3;
    check("reset_hold", hold_a, 1'b0);
    check("reset_fwd", fwd_a, 4'd0);
    check("reset_stall", stall_a, 16'd0);
    repeat (2) next_cycle();
    reset_n = 1'b1;
    next_cycle();

    // ALU r5 then back-to-back read: stage 1, then stage 2.
    drive(1'b1, 6'd0, 6'd0, 2'b00, 1'b1, 6'd5, 1'b0, 1'b0);
    #3 check("alu_issue_hold", hold_a, 1'b0);
    next_cycle();
    drive(1'b1, 6'd5, 6'd0, 2'b01, 1'b0, 6'd0, 1'b0, 1'b0);
    #3 check("alu_fwd_hold", hold_a, 1'b0);
    check("alu_fwd_sel1", fwd_a, 4'd1);
    next_cycle();
    #3 check("alu_fwd_sel2", fwd_a, 4'd2);
    drain();

    // Load r7 then read on operand 1: one-cycle load-use hold.
    drive(1'b1, 6'd0, 6'd0, 2'b00, 1'b1, 6'd7, 1'b1, 1'b0);
    next_cycle();
    drive(1'b1, 6'd0, 6'd7, 2'b10, 1'b0, 6'd0, 1'b0, 1'b0);
    #3 check("lu_hold", hold_a, 1'b1);
    check("lu_hold_fwd", fwd_a, 4'd0);
    check("lu_stall0", stall_a, 16'd0);
    next_cycle();
    #3 check("lu_release", hold_a, 1'b0);
    check("lu_fwd_sel", fwd_a, 4'b1000);
    check("lu_stall1", stall_a, 16'd1);
    drain();

    // Two writes to r3: youngest (stage 1) wins; r10 reads the register file.
    drive(1'b1, 6'd0, 6'd0, 2'b00, 1'b1, 6'd3, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    drive(1'b1, 6'd3, 6'd10, 2'b11, 1'b0, 6'd0, 1'b0, 1'b0);
    #3 check("youngest_sel", fwd_a, 4'b0001);
    drain();

    // Operands matching different stages get independent selects.
    drive(1'b1, 6'd0, 6'd0, 2'b00, 1'b1, 6'd1, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 6'd0, 6'd0, 2'b00, 1'b1, 6'd2, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 6'd2, 6'd1, 2'b11, 1'b0, 6'd0, 1'b0, 1'b0);
    #3 check("dual_sel", fwd_a, 4'b1001);
    check("dual_hold", hold_a, 1'b0);
    drain();

    // Register 0 never creates a hazard.
    drive(1'b1, 6'd0, 6'd0, 2'b00, 1'b1, 6'd0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 6'd0, 6'd0, 2'b11, 1'b0, 6'd0, 1'b0, 1'b0);
    #3 check("r0_hold", hold_a, 1'b0);
    check("r0_sel", fwd_a, 4'd0);
    drain();

    // Flush together with a load-use hazard: no hold, scoreboard emptied.
    drive(1'b1, 6'd0, 6'd0, 2'b00, 1'b1, 6'd9, 1'b1, 1'b0);
    next_cycle();
    drive(1'b1, 6'd9, 6'd0, 2'b01, 1'b0, 6'd0, 1'b0, 1'b1);
    #3 check("flush_hold", hold_a, 1'b0);
    check("flush_fwd", fwd_a, 4'd0);
    next_cycle();
    drive(1'b1, 6'd9, 6'd0, 2'b01, 1'b0, 6'd0, 1'b0, 1'b0);
    #3 check("post_flush_hold", hold_a, 1'b0);
    check("post_flush_sel", fwd_a, 4'd0);
    check("post_flush_stall", stall_a, 16'd1);
    drain();

    // No forwarding: ALU r4 then read r4 holds for DEPTH cycles.
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    next_cycle();
    drive(1'b1, 6'd0, 6'd0, 2'b00, 1'b1, 6'd4, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 6'd4, 6'd0, 2'b01, 1'b0, 6'd0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #3 check($sformatf("nf_hold_c%0d", c), hold_n, 1'b1);
      check($sformatf("nf_fwd_c%0d", c), fwd_n, 4'd0);
      next_cycle();
    end
    #3 check("nf_release", hold_n, 1'b0);
    check("nf_sel_rf", fwd_n, 4'd0);
    check("nf_stall", stall_n, 16'd3);
    drain();

    // Long stall stream saturates the counter.
    sat_run = 1'b1;
    repeat (72000) next_cycle();
    #3 check("sat_stall", stall_s, 16'hFFFF);
    next_cycle();
    #3 check("sat_stall_hold", stall_s, 16'hFFFF);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (hold_s) seen = 1'b1;
      else next_cycle();
    end
    check("sat_hold_seen", seen, 1'b1);

    // Asynchronous reset mid-stall clears outputs and counter at once.
    reset_n = 1'b0;
    #1;
    check("rst_mid_hold", hold_s, 1'b0);
    check("rst_mid_fwd", fwd_s, 4'd0);
    check("rst_mid_stall", stall_s, 16'd0);
    check("rst_mid_stall_a", stall_a, 16'd0);
    sat_run = 1'b0;
    #2 reset_n = 1'b1;
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
